// File: rtl/stage_seq_pkg.sv
// Shared types and default sizing for the stage sequencer.
package stage_seq_pkg;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } seq_state_e;

  localparam int unsigned DEF_NUM_STAGES   = 5;
  localparam int unsigned DEF_RESET_CYCLES = 2;
  localparam int unsigned DEF_COUNT_WIDTH  = 32;

endpackage

// File: rtl/stage_sequencer_if.sv
// Control bundle between the stage sequencer and the datapath it drives.
interface stage_sequencer_if
  import stage_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES  = DEF_NUM_STAGES,
  parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH
) ();

  logic [NUM_STAGES-1:0]         stage_ready;
  logic                          halt;
  logic                          flush;
  logic                          stage_reset_n;
  logic [NUM_STAGES-1:0]         stage_wren;
  logic                          pc_wren;
  logic                          ram_wren;
  logic                          reg_wren;
  logic [$clog2(NUM_STAGES)-1:0] active_stage;
  logic                          running;
  logic [COUNT_WIDTH-1:0]        retired_count;

  // Sequencer side
  modport master (
    input  stage_ready, halt, flush,
    output stage_reset_n, stage_wren, pc_wren, ram_wren, reg_wren,
           active_stage, running, retired_count
  );

  // Datapath side
  modport slave (
    output stage_ready, halt, flush,
    input  stage_reset_n, stage_wren, pc_wren, ram_wren, reg_wren,
           active_stage, running, retired_count
  );

endinterface

// File: rtl/stage_sequencer.sv
// Stage sequencer: steps a multi-cycle or pipelined datapath through its stages
// and produces the register/commit write strobes.
module stage_sequencer
  import stage_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES   = DEF_NUM_STAGES,
  parameter bit          PIPELINED    = 1'b0,
  parameter int unsigned MEM_STAGE    = NUM_STAGES - 2,
  parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int unsigned COUNT_WIDTH  = DEF_COUNT_WIDTH
) (
  input logic               clk,
  input logic               reset_n,
  stage_sequencer_if.master bus
);

  localparam int unsigned     SW        = $clog2(NUM_STAGES);
  localparam logic [SW-1:0]   LAST      = SW'(NUM_STAGES - 1);
  localparam logic [3:0]      HOLD_LAST = 4'(RESET_CYCLES - 1);

  seq_state_e             state_q, state_d;
  logic [3:0]             hold_q, hold_d;
  logic [SW-1:0]          s_q, s_d, s_adv;
  logic                   halt_q, halt_d;
  logic [COUNT_WIDTH-1:0] retired_q;

  logic                   in_run, adv, retire, boundary, mem_hit, last_hit;
  logic [NUM_STAGES-1:0]  wren;

  assign in_run = (state_q == RUN);

  generate
    if (PIPELINED == 1'b0) begin : g_seq
      localparam logic [SW-1:0] MEM_S = SW'(MEM_STAGE);

      always_comb begin
        adv      = in_run & bus.stage_ready[s_q] & ~bus.flush;
        wren     = '0;
        if (adv) wren[s_q] = 1'b1;
        mem_hit  = adv & (s_q == MEM_S);
        last_hit = adv & (s_q == LAST);
        retire   = last_hit;
        boundary = last_hit;
        s_adv    = (s_q == LAST) ? '0 : s_q + 1'b1;
      end
    end else begin : g_pipe
      logic [SW-1:0] fill_q;

      always_comb begin
        adv      = in_run & (&bus.stage_ready) & ~bus.flush;
        wren     = {NUM_STAGES{adv}};
        mem_hit  = adv;
        last_hit = adv;
        retire   = adv & (fill_q == LAST);
        boundary = 1'b1;
        s_adv    = '0;
      end

      // Held at zero outside RUN so every RUN entry starts a fresh fill.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          fill_q <= '0;
        end else if (!in_run || bus.flush) begin
          fill_q <= '0;
        end else if (adv && (fill_q != LAST)) begin
          fill_q <= fill_q + 1'b1;
        end
      end
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    s_d     = s_q;
    halt_d  = halt_q;
    unique case (state_q)
      HOLD: begin
        s_d    = '0;
        halt_d = 1'b0;
        if (hold_q == HOLD_LAST) begin
          state_d = RUN;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      RUN: begin
        halt_d = halt_q | bus.halt;
        if (bus.flush)  s_d = '0;
        else if (adv)   s_d = s_adv;
        // A flush is an instruction boundary too, so a pending halt takes it.
        if ((halt_q | bus.halt) && (bus.flush || boundary)) state_d = HALTED;
      end
      HALTED: begin
        s_d = '0;
        if (!bus.halt) begin
          state_d = RUN;
          halt_d  = 1'b0;
        end
      end
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= HOLD;
      hold_q    <= '0;
      s_q       <= '0;
      halt_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      s_q     <= s_d;
      halt_q  <= halt_d;
      if (retire) retired_q <= retired_q + 1'b1;
    end
  end

  assign bus.stage_reset_n = (state_q != HOLD);
  assign bus.running       = in_run;
  assign bus.stage_wren    = wren;
  assign bus.ram_wren      = mem_hit;
  assign bus.pc_wren       = last_hit;
  assign bus.reg_wren      = last_hit;
  assign bus.active_stage  = s_q;
  assign bus.retired_count = retired_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: a sequential 5-stage instance and a
// pipelined 4-stage instance, exercised one at a time against a reference model.
module tb_stage_sequencer;
  import stage_seq_pkg::*;

  logic clk  = 1'b0;
  logic rn_a = 1'b0;
  logic rn_b = 1'b0;
  always #5 clk = ~clk;

  stage_sequencer_if #(.NUM_STAGES(5), .COUNT_WIDTH(32)) bus_a ();
  stage_sequencer_if #(.NUM_STAGES(4), .COUNT_WIDTH(32)) bus_b ();

  stage_sequencer #(.NUM_STAGES(5), .PIPELINED(1'b0), .MEM_STAGE(3),
                    .RESET_CYCLES(2), .COUNT_WIDTH(32))
    dut_a (.clk(clk), .reset_n(rn_a), .bus(bus_a));

  stage_sequencer #(.NUM_STAGES(4), .PIPELINED(1'b1), .MEM_STAGE(2),
                    .RESET_CYCLES(3), .COUNT_WIDTH(32))
    dut_b (.clk(clk), .reset_n(rn_b), .bus(bus_b));

  int tests = 0;
  int fails = 0;

  // Reference model: mode 0=reset hold, 1=running, 2=halted.
  int          cur, N, P, MEM, RC;
  int          ms, mhold, mstage, mfill;
  logic        mhalt;
  logic [31:0] mret;
  logic [16:0] last_got;
  logic [31:0] last_ret;

  typedef struct {
    logic [7:0] ready;
    logic [7:0] wren;
    logic       ram;
    logic       pcreg;
    logic       srn;
  } vec_t;
  vec_t tab_a[7];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic select(input int d);
    cur = d;
    N   = (d == 0) ? 5 : 4;
    P   = d;
    MEM = (d == 0) ? 3 : 2;
    RC  = (d == 0) ? 2 : 3;
  endtask

  task automatic drive(input logic [7:0] r, input logic h, input logic f);
    bus_a.stage_ready = (cur == 0) ? r[4:0] : 5'd0;
    bus_a.halt        = (cur == 0) ? h : 1'b0;
    bus_a.flush       = (cur == 0) ? f : 1'b0;
    bus_b.stage_ready = (cur == 1) ? r[3:0] : 4'd0;
    bus_b.halt        = (cur == 1) ? h : 1'b0;
    bus_b.flush       = (cur == 1) ? f : 1'b0;
  endtask

  task automatic read_outs(output logic [16:0] o, output logic [31:0] r);
    if (cur == 0) begin
      o = {8'(bus_a.stage_wren), bus_a.pc_wren, bus_a.ram_wren, bus_a.reg_wren,
           4'(bus_a.active_stage), bus_a.running, bus_a.stage_reset_n};
      r = bus_a.retired_count;
    end else begin
      o = {8'(bus_b.stage_wren), bus_b.pc_wren, bus_b.ram_wren, bus_b.reg_wren,
           4'(bus_b.active_stage), bus_b.running, bus_b.stage_reset_n};
      r = bus_b.retired_count;
    end
  endtask

  task automatic model_reset();
    ms = 0; mhold = 0; mstage = 0; mfill = 0; mhalt = 1'b0; mret = '0;
  endtask

  task automatic model_exp(input logic [7:0] r, input logic f, output logic [16:0] e);
    logic [7:0] w, mask;
    logic       pc, ram;
    logic [3:0] act;
    mask = 8'((1 << N) - 1);
    w = '0; pc = 1'b0; ram = 1'b0;
    act = (P != 0) ? 4'd0 : 4'(mstage);
    if (ms == 1) begin
      if (P == 0) begin
        if (r[mstage] && !f) begin
          w   = 8'(1 << mstage);
          ram = (mstage == MEM);
          pc  = (mstage == N - 1);
        end
      end else if (((r & mask) == mask) && !f) begin
        w = mask; ram = 1'b1; pc = 1'b1;
      end
    end
    e = {w, pc, ram, pc, act, (ms == 1), (ms != 0)};
  endtask

  task automatic model_upd(input logic [7:0] r, input logic h, input logic f);
    logic [7:0] mask;
    logic pend, wrapped, adv;
    mask = 8'((1 << N) - 1);
    wrapped = 1'b0;
    case (ms)
      0: begin
        mhold++;
        if (mhold == RC) begin ms = 1; mstage = 0; mfill = 0; end
      end
      1: begin
        pend = mhalt || h;
        if (h) mhalt = 1'b1;
        if (P == 0) begin
          adv = r[mstage] && !f;
          if (f) mstage = 0;
          else if (adv) begin
            if (mstage == N - 1) begin mstage = 0; mret++; wrapped = 1'b1; end
            else mstage++;
          end
          if (pend && (f || wrapped)) ms = 2;
        end else begin
          adv = ((r & mask) == mask) && !f;
          if (f) mfill = 0;
          else if (adv) begin
            if (mfill >= N - 1) mret++;
            else mfill++;
          end
          if (pend) ms = 2;
        end
      end
      default: begin
        mstage = 0;
        if (!h) begin ms = 1; mhalt = 1'b0; mfill = 0; end
      end
    endcase
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic cycle(input logic [7:0] r, input logic h, input logic f);
    logic [16:0] e, o;
    logic [31:0] rv;
    drive(r, h, f);
    model_exp(r, f, e);
    @(negedge clk);
    read_outs(o, rv);
    chk("outputs", o, e);
    chk("retired", rv, mret);
    last_got = o;
    last_ret = rv;
    @(posedge clk);
    model_upd(r, h, f);
    #1;
  endtask

  task automatic do_reset();
    logic [16:0] o;
    logic [31:0] rv;
    drive(8'h00, 1'b0, 1'b0);
    if (cur == 0) rn_a = 1'b0; else rn_b = 1'b0;
    model_reset();
    #1;
    read_outs(o, rv);
    chk("reset_state", o, 17'h0);
    chk("reset_retired", rv, 32'h0);
    @(posedge clk);
    #1;
    if (cur == 0) rn_a = 1'b1; else rn_b = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          n, cnt, stall;
    logic        done;
    logic [31:0] r0;
    logic [16:0] o;
    logic [31:0] rv;

    tab_a[0] = '{8'h1f, 8'h00, 1'b0, 1'b0, 1'b0};
    tab_a[1] = '{8'h1f, 8'h00, 1'b0, 1'b0, 1'b0};
    tab_a[2] = '{8'h1f, 8'h01, 1'b0, 1'b0, 1'b1};
    tab_a[3] = '{8'h1f, 8'h02, 1'b0, 1'b0, 1'b1};
    tab_a[4] = '{8'h1f, 8'h04, 1'b0, 1'b0, 1'b1};
    tab_a[5] = '{8'h1f, 8'h08, 1'b1, 1'b0, 1'b1};
    tab_a[6] = '{8'h1f, 8'h10, 1'b0, 1'b1, 1'b1};

    select(0);
    drive(8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    do_reset();

    // Reset release and one full instruction walk
    for (int i = 0; i < 7; i++) begin
      cycle(tab_a[i].ready, 1'b0, 1'b0);
      chk("walk_wren", last_got[16:9], tab_a[i].wren);
      chk("walk_ram",  last_got[7],    tab_a[i].ram);
      chk("walk_pc",   last_got[8],    tab_a[i].pcreg);
      chk("walk_reg",  last_got[6],    tab_a[i].pcreg);
      chk("walk_srn",  last_got[0],    tab_a[i].srn);
    end

    // Stage 3 stalls for 7 cycles
    n = 0; stall = 7; done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      logic [7:0] r;
      logic       stalled;
      r = 8'h1f; stalled = 1'b0;
      if (mstage == 3 && stall > 0) begin r = 8'h17; stall--; stalled = 1'b1; end
      cycle(r, 1'b0, 1'b0);
      if (i == 0) chk("retired_after_walk", last_ret, 32'd1);
      if (stalled) begin
        chk("stall_act",  last_got[5:2],  4'd3);
        chk("stall_wren", last_got[16:9], 8'h00);
      end
      n++;
      if (last_got[8]) done = 1'b1;
    end
    chk("stall_done", done, 1'b1);
    chk("stall_len", n, 12);

    // Flush at stage 2
    cycle(8'h1f, 1'b0, 1'b0);
    cycle(8'h1f, 1'b0, 1'b0);
    cycle(8'h1f, 1'b0, 1'b1);
    chk("flush_wren", last_got[16:9], 8'h00);
    cycle(8'h00, 1'b0, 1'b0);
    chk("flush_act", last_got[5:2], 4'd0);
    chk("flush_retired", last_ret, 32'd2);

    // Halt raised at stage 1 and held
    cycle(8'h1f, 1'b0, 1'b0);
    cnt = 0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      cycle(8'h1f, 1'b1, 1'b0);
      if (!last_got[1]) done = 1'b1;
      else if (last_got[16:9] != 8'h00) cnt++;
    end
    chk("halt_reached", done, 1'b1);
    chk("halt_strobes", cnt, 4);
    cycle(8'h1f, 1'b1, 1'b0);
    chk("halted_wren", last_got[16:9], 8'h00);
    cycle(8'h1f, 1'b0, 1'b0);
    chk("halted_running", last_got[1], 1'b0);
    cycle(8'h1f, 1'b0, 1'b0);
    chk("restart_running", last_got[1], 1'b1);
    chk("restart_wren", last_got[16:9], 8'h01);

    // Asynchronous reset between edges at stage 3
    cycle(8'h1f, 1'b0, 1'b0);
    cycle(8'h1f, 1'b0, 1'b0);
    drive(8'h1f, 1'b0, 1'b0);
    #1;
    read_outs(o, rv);
    chk("pre_reset_wren", o[16:9], 8'h08);
    #1;
    rn_a = 1'b0;
    model_reset();
    #1;
    read_outs(o, rv);
    chk("async_reset_outs", o, 17'h0);
    chk("async_reset_retired", rv, 32'h0);
    @(posedge clk);
    #1;
    rn_a = 1'b1;
    cycle(8'h1f, 1'b0, 1'b0);
    chk("hold_restart", last_got[0], 1'b0);

    // Randomized sequential traffic
    begin
      logic h;
      h = 1'b0;
      for (int i = 0; i < 400; i++) begin
        logic [7:0] r;
        logic       f;
        r = 8'($urandom | $urandom);
        f = ($urandom_range(0, 24) == 0);
        if ($urandom_range(0, 14) == 0) h = ~h;
        cycle(r, h, f);
      end
    end

    // Pipelined instance
    rn_a = 1'b0;
    select(1);
    do_reset();
    for (int i = 0; i < 3; i++) cycle(8'h0f, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(8'h0f, 1'b0, 1'b0);
      chk("pipe_wren", last_got[16:9], 8'h0f);
      chk("pipe_commit", last_got[8:6], 3'b111);
    end
    cycle(8'h0b, 1'b0, 1'b0);
    chk("pipe_retired", last_ret, 32'd7);
    chk("pipe_block_wren", last_got[16:9], 8'h00);

    r0 = mret;
    cycle(8'h0f, 1'b0, 1'b1);
    chk("pipe_flush_wren", last_got[16:9], 8'h00);
    for (int i = 0; i < 3; i++) cycle(8'h0f, 1'b0, 1'b0);
    cycle(8'h0f, 1'b0, 1'b0);
    chk("pipe_refill", last_ret, r0);
    cycle(8'h0f, 1'b0, 1'b0);
    chk("pipe_refill_done", last_ret, r0 + 32'd1);

    cycle(8'h0f, 1'b1, 1'b0);
    cycle(8'h0f, 1'b0, 1'b0);
    chk("pipe_halted", last_got[1], 1'b0);
    cycle(8'h0f, 1'b0, 1'b0);
    chk("pipe_resumed", last_got[1], 1'b1);

    begin
      logic h;
      h = 1'b0;
      for (int i = 0; i < 400; i++) begin
        logic [7:0] r;
        logic       f;
        r = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0f;
        f = ($urandom_range(0, 24) == 0);
        if ($urandom_range(0, 14) == 0) h = ~h;
        cycle(r, h, f);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 5, stage count in range 2..8; stage 0 = fetch, stage NUM_STAGES-1 = writeback.
REQ-002 SHALL have parameter PIPELINED, default 0: 0 = multi-cycle (one stage active per instruction step), 1 = all stages advance together.
REQ-003 SHALL have parameter MEM_STAGE, default NUM_STAGES-2, the index of the stage that owns the RAM write strobe.
REQ-004 SHALL have parameter RESET_CYCLES, default 2, range 1..15, the post-reset cycles with stage_reset_n held low.
REQ-005 SHALL have parameter COUNT_WIDTH, default 32, the width of the retired-instruction counter.
REQ-006 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port stage_ready, input, NUM_STAGES, bit k = stage k result valid this cycle (a multi-cycle RAM/ALU holds it low).
REQ-009 SHALL have port halt, input, 1, level request to stop at the next instruction boundary.
REQ-010 SHALL have port flush, input, 1, single-cycle pulse that aborts in-flight work.
REQ-011 SHALL have port stage_reset_n, output, 1, active-low clear for all pipeline registers.
REQ-012 SHALL have port stage_wren, output, NUM_STAGES, bit k = write enable of the register after stage k.
REQ-013 SHALL have ports pc_wren, ram_wren and reg_wren, each output, 1, single-cycle commit strobes.
REQ-014 SHALL have port active_stage, output, $clog2(NUM_STAGES), current stage pointer (0 when PIPELINED=1).
REQ-015 SHALL have port running, output, 1, high only in state RUN.
REQ-016 SHALL have port retired_count, output, COUNT_WIDTH, count of completed instructions.

Function
REQ-017 FSM states SHALL be HOLD, RUN and HALTED.
REQ-018 HOLD SHALL drive stage_reset_n=0 and count RESET_CYCLES cycles, then enter RUN with active_stage=0.
REQ-019 Strobes SHALL be combinational from registered state plus stage_ready/flush (same-cycle response) and SHALL be 0 outside RUN.
REQ-020 Sequential, RUN: when stage_ready[s]=1, flush=0, the block SHALL pulse stage_wren[s] for 1 cycle and set s to s+1, wrapping NUM_STAGES-1 to 0.
REQ-021 Sequential: stage_ready[s]=0 SHALL leave s unchanged and keep all strobes 0 (stall of unbounded length).
REQ-022 Sequential: ram_wren SHALL equal the advance of s==MEM_STAGE; reg_wren and pc_wren SHALL equal the advance of s==NUM_STAGES-1.
REQ-023 Sequential: each wrap SHALL increment retired_count by 1, modulo 2^COUNT_WIDTH.
REQ-024 Pipelined: advance SHALL be &stage_ready & ~flush in RUN; on advance all stage_wren bits, pc_wren, ram_wren and reg_wren SHALL equal 1.
REQ-025 Pipelined: a fill counter SHALL suppress retired_count increments for the first NUM_STAGES-1 advances after RUN entry or flush.
REQ-026 flush in RUN SHALL win over ready: no strobes that cycle, s set to 0, fill counter cleared, retired_count unchanged, stage_reset_n stays 1.
REQ-027 halt SHALL be latched; sequential mode enters HALTED on the wrap advance, pipelined mode enters HALTED on the next cycle with no advance.
REQ-028 HALTED SHALL leave s at 0 and retired_count frozen, and return to RUN the cycle after halt=0.
REQ-029 Simultaneous halt and flush SHALL apply the flush and then enter HALTED.

Reset
REQ-030 reset_n=0 SHALL immediately, regardless of clock, clear state to HOLD, s, hold and fill counters, retired_count and latched halt to 0, all strobes to 0, stage_reset_n to 0 and running to 0.
REQ-031 Reset asserted mid-instruction SHALL discard that instruction without any further strobe.

Structure
REQ-032 The shared package stage_seq_pkg SHALL hold the state enum and default constants for NUM_STAGES, RESET_CYCLES and COUNT_WIDTH.
REQ-033 The design SHALL be flat with no sub-module; both modes SHALL be generate branches selected by PIPELINED.

Verification
REQ-034 Reset release, defaults, stage_ready all 1: stage_reset_n low for exactly 2 cycles, then stage_wren walks 00001 to 10000 over 5 cycles; pc_wren and reg_wren coincide with 10000, ram_wren with 01000, retired_count=1.
REQ-035 stage_ready[3] held low for 7 cycles: no strobes in those cycles, active_stage=3, then completion proceeds; instruction takes 12 cycles.
REQ-036 flush asserted with s=2 and stage_ready=1: no strobe that cycle, active_stage=0 next cycle, retired_count unchanged.
REQ-037 halt asserted at s=1: strobes for stages 1 to 4 still occur, then running=0 and strobes stay 0; halt=0 restarts at stage 0.
REQ-038 PIPELINED=1, NUM_STAGES=4, ready all 1 for 10 cycles: stage_wren=1111 each cycle, retired_count=7; one ready bit low blocks all strobes that cycle.
REQ-039 reset_n pulsed low between clock edges at s=3: outputs go to reset values before the next edge, and HOLD restarts.
